// File: rtl/fib_pkg.sv
// Shared types for the generalised-Fibonacci sequence engine.
// Holds the engine FSM state encoding.
package fib_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/fib_seq_engine_if.sv
// Term stream port of the Fibonacci engine: valid/ready handshake.
// master drives terms, slave consumes them.
interface fib_seq_engine_if #(
  parameter int WIDTH = 32
);

  logic             term_valid;
  logic             term_ready;
  logic [WIDTH-1:0] term;
  logic             term_last;

  modport master (
    output term_valid,
    output term,
    output term_last,
    input  term_ready
  );

  modport slave (
    input  term_valid,
    input  term,
    input  term_last,
    output term_ready
  );

endinterface

// File: rtl/fib_add.sv
// Unsigned WIDTH-bit adder with carry out for the Fibonacci engine.
// FIB_SAT_EN: clamp the sum to all-ones on carry instead of wrapping.
module fib_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] full;

  // full-width sum, carry taken from the extra bit
  always_comb begin
    full  = {1'b0, a} + {1'b0, b};
    carry = full[WIDTH];
`ifdef FIB_SAT_EN
    sum   = carry ? '1 : full[WIDTH-1:0];
`else
    sum   = full[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/fib_seq_engine.sv
// Generalised-Fibonacci generator: streams F(0)..F(n), latches F(n).
// Optional macro FIB_SAT_EN selects saturating additions.
module fib_seq_engine
  import fib_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_WIDTH-1:0] n,
  input  logic [WIDTH-1:0]   seed0,
  input  logic [WIDTH-1:0]   seed1,
  output logic               busy,
  fib_seq_engine_if.master   strm,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               a_c_q;
  logic               b_c_q;
  logic [N_WIDTH-1:0] k_q;
  logic [N_WIDTH-1:0] lim_q;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic               launch;
  logic               xfer;
  logic               is_last;

  fib_add #(
    .WIDTH (WIDTH)
  ) u_add (
    .a     (a_q),
    .b     (b_q),
    .sum   (sum),
    .carry (carry)
  );

  assign launch  = (state_q == IDLE) && start;
  assign xfer    = (state_q == RUN) && strm.term_ready;
  assign is_last = (k_q == lim_q);

  assign busy           = (state_q == RUN);
  assign strm.term_valid = busy;
  assign strm.term       = a_q;
  assign strm.term_last  = busy && is_last;

  // next state: launch on start, return after final term is taken
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (xfer && is_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // term pipeline, index, result, done pulse and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      a_c_q    <= 1'b0;
      b_c_q    <= 1'b0;
      k_q      <= '0;
      lim_q    <= '0;
      result   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        launch: begin
          a_q      <= seed0;
          b_q      <= seed1;
          a_c_q    <= 1'b0;
          b_c_q    <= 1'b0;
          k_q      <= '0;
          lim_q    <= n;
          overflow <= 1'b0;
        end
        xfer: begin
          if (a_c_q) overflow <= 1'b1;
          if (is_last) begin
            result <= a_q;
            done   <= 1'b1;
          end else begin
            a_q   <= b_q;
            a_c_q <= b_c_q;
            b_q   <= sum;
            b_c_q <= carry;
            k_q   <= k_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_seq_engine.sv
// Directed bench for fib_seq_engine: 32-bit and 8-bit instances
// share stimulus; each vector checks stream, result, overflow, timing.
module tb_fib_seq_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  n;
  logic [31:0] s0;
  logic [31:0] s1;
  logic        rdy;

  logic        busy32, done32, ovf32;
  logic [31:0] res32;
  logic        busy8, done8, ovf8;
  logic [7:0]  res8;

  int errs   = 0;
  int checks = 0;

  fib_seq_engine_if #(.WIDTH(32)) i32 ();
  fib_seq_engine_if #(.WIDTH(8))  i8 ();

  assign i32.term_ready = rdy;
  assign i8.term_ready  = rdy;

  fib_seq_engine #(.WIDTH(32), .N_WIDTH(6)) u32 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n        (n),
    .seed0    (s0),
    .seed1    (s1),
    .busy     (busy32),
    .strm     (i32),
    .done     (done32),
    .result   (res32),
    .overflow (ovf32)
  );

  fib_seq_engine #(.WIDTH(8), .N_WIDTH(6)) u8 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n        (n),
    .seed0    (s0[7:0]),
    .seed1    (s1[7:0]),
    .busy     (busy8),
    .strm     (i8),
    .done     (done8),
    .result   (res8),
    .overflow (ovf8)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nn;
    logic [31:0] sd0;
    logic [31:0] sd1;
    bit          rnd;
    bit          w8;
    int          mid;
    logic [31:0] exp_res;
    bit          exp_ovf;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    logic [63:0] mask;
    logic [63:0] ea, eb, es;
    logic        vld, lst, dn, bsy, ov;
    logic [31:0] trm, res, prev;
    bit          stalled;
    int          edges, ntr, lat;
    mask  = v.w8 ? 64'hFF : 64'hFFFF_FFFF;
    ea    = {32'd0, v.sd0} & mask;
    eb    = {32'd0, v.sd1} & mask;
    rdy   = 1'b1;
    start = 1'b1;
    n     = v.nn[5:0];
    s0    = v.sd0;
    s1    = v.sd1;
    @(posedge clk);
    edges   = 0;
    ntr     = 0;
    lat     = -1;
    stalled = 1'b0;
    prev    = '0;
    for (int c = 0; c < 400 && lat < 0; c++) begin
      @(negedge clk);
      start = (c == v.mid);
      if (c == v.mid) begin
        n  = 6'd3;
        s0 = 32'd5;
        s1 = 32'd5;
      end
      vld = v.w8 ? i8.term_valid : i32.term_valid;
      lst = v.w8 ? i8.term_last : i32.term_last;
      trm = v.w8 ? {24'd0, i8.term} : i32.term;
      dn  = v.w8 ? done8 : done32;
      if (dn) begin
        lat = edges + 1;
      end else begin
        rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (stalled) begin
          chk("hold_valid", {63'd0, vld}, 64'd1);
          chk("hold_term", {32'd0, trm}, {32'd0, prev});
        end
        if (vld && rdy) begin
          chk("term", {32'd0, trm}, ea);
          chk("term_last", {63'd0, lst}, {63'd0, ntr == v.nn});
          es = ea + eb;
`ifdef FIB_SAT_EN
          if (es > mask) es = mask;
`endif
          es = es & mask;
          ea = eb;
          eb = es;
          ntr++;
        end
        stalled = vld && !rdy;
        prev    = trm;
        @(posedge clk);
        edges++;
      end
    end
    start = 1'b0;
    if (lat < 0) begin
      errs++;
      checks++;
      $display("FAIL done_timeout: got none expected done n=%0d", v.nn);
    end
    res = v.w8 ? {24'd0, res8} : res32;
    ov  = v.w8 ? ovf8 : ovf32;
    bsy = v.w8 ? busy8 : busy32;
    chk("transfers", 64'(ntr), 64'(v.nn + 1));
    chk("result", {32'd0, res}, {32'd0, v.exp_res});
    chk("overflow", {63'd0, ov}, {63'd0, v.exp_ovf});
    chk("busy_at_done", {63'd0, bsy}, 64'd0);
    if (!v.rnd) chk("done_latency", 64'(lat), 64'(v.nn + 2));
  endtask

  initial begin
    int dcnt;
    vt[0] = '{10, 32'd0, 32'd1, 1'b0, 1'b0, -1, 32'd55, 1'b0};
    vt[1] = '{0, 32'd7, 32'd9, 1'b0, 1'b0, -1, 32'd7, 1'b0};
`ifdef FIB_SAT_EN
    vt[2] = '{14, 32'd0, 32'd1, 1'b0, 1'b1, -1, 32'd255, 1'b1};
    vt[6] = '{48, 32'd0, 32'd1, 1'b0, 1'b0, -1, 32'hFFFF_FFFF, 1'b1};
`else
    vt[2] = '{14, 32'd0, 32'd1, 1'b0, 1'b1, -1, 32'd121, 1'b1};
    vt[6] = '{48, 32'd0, 32'd1, 1'b0, 1'b0, -1, 32'd512559680, 1'b1};
`endif
    vt[3] = '{13, 32'd0, 32'd1, 1'b0, 1'b1, -1, 32'd233, 1'b0};
    vt[4] = '{10, 32'd0, 32'd1, 1'b1, 1'b0, -1, 32'd55, 1'b0};
    vt[5] = '{10, 32'd0, 32'd1, 1'b0, 1'b0, 3, 32'd55, 1'b0};
    vt[7] = '{4, 32'd2, 32'd1, 1'b0, 1'b0, -1, 32'd7, 1'b0};
    vt[8] = '{63, 32'd0, 32'd0, 1'b0, 1'b0, -1, 32'd0, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    n     = '0;
    s0    = '0;
    s1    = '0;
    rdy   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy32}, 64'd0);
    chk("rst_valid", {63'd0, i32.term_valid}, 64'd0);
    chk("rst_last", {63'd0, i32.term_last}, 64'd0);
    chk("rst_done", {63'd0, done32}, 64'd0);
    chk("rst_ovf", {63'd0, ovf32}, 64'd0);
    chk("rst_term", {32'd0, i32.term}, 64'd0);
    chk("rst_result", {32'd0, res32}, 64'd0);
    chk("rst_busy8", {63'd0, busy8}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run(vt[i]);

    @(negedge clk);
    chk("done_one_cycle", {63'd0, done32}, 64'd0);

    start = 1'b1;
    n     = 6'd10;
    s0    = 32'd0;
    s1    = 32'd1;
    rdy   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_term", {32'd0, i32.term}, 64'd5);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {63'd0, busy32}, 64'd0);
    chk("mid_rst_valid", {63'd0, i32.term_valid}, 64'd0);
    chk("mid_rst_result", {32'd0, res32}, 64'd0);
    chk("mid_rst_term", {32'd0, i32.term}, 64'd0);
    rst  = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done32) dcnt++;
    end
    chk("no_done_after_rst", 64'(dcnt), 64'd0);

    run(vt[0]);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
